// File: rtl/seq_digit_multiplier.sv
// Sequential digit-serial multiplier: consumes D multiplier bits per cycle into a 2W-bit accumulator.
// Optional MULT_SIGNED_EN macro adds an sgn input for two's-complement operands.
module seq_digit_multiplier #(
  parameter int W = 8,
  parameter int D = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
`ifdef MULT_SIGNED_EN
  input  logic           sgn,
`endif
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] o,
  output logic           busy
);

  localparam int STEPS = W / D;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((W < 2) || (D < 1) || (D > W) || ((W % D) != 0)) begin : g_bad_params
    $error("seq_digit_multiplier: W must be >= 2 and a multiple of D");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [2*W-1:0]   x_ext;
  logic [W-1:0]     y_reg;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    step;
  logic [D-1:0]     digit;
  logic             last_step;
  logic [2*W-1:0]   pp;
  logic [2*W-1:0]   sum;
`ifdef MULT_SIGNED_EN
  logic             sgn_reg;
  logic             neg_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_step) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  assign digit     = y_reg[int'(step)*D +: D];
  assign last_step = (step == CW'(STEPS - 1));
`ifdef MULT_SIGNED_EN
  // In signed mode the top multiplier bit carries weight -2^(W-1), so it is subtracted.
  assign neg_msb   = sgn_reg && last_step;
`endif

  // And-array for one digit, then shifted into place and added to the accumulator.
  always_comb begin
    pp = '0;
    for (int j = 0; j < D; j++) begin
      if (digit[j]) begin
`ifdef MULT_SIGNED_EN
        if ((j == D - 1) && neg_msb) begin
          pp = pp - (x_ext << j);
        end else begin
          pp = pp + (x_ext << j);
        end
`else
        pp = pp + (x_ext << j);
`endif
      end
    end
    sum = acc + (pp << (int'(step) * D));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_ext <= '0;
      y_reg <= '0;
      acc   <= '0;
      step  <= '0;
      o     <= '0;
`ifdef MULT_SIGNED_EN
      sgn_reg <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef MULT_SIGNED_EN
            x_ext   <= {{W{sgn & x[W-1]}}, x};
            sgn_reg <= sgn;
`else
            x_ext   <= {{W{1'b0}}, x};
`endif
            y_reg <= y;
            acc   <= '0;
            step  <= '0;
          end
        end
        RUN: begin
          acc <= sum;
          if (last_step) begin
            step <= '0;
            o    <= sum;
          end else begin
            step <= step + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
